fifo_1d_64to16: RTL and testbench
=================================

// Module: fifo_1d_64to16
// PURPOSE
//  Width downsizer FIFO: accepts 64-bit words and emits them as 16-bit parcels,
//  higher-order parcel first ([63:48], [47:32], [31:16], [15:0]). This matches
//  the packing order used by the 16-to-64 upsizer.
//  Sits between 64-bit fetch/memory return paths and 16-bit parcel consumers
//  such as the compressed-instruction aligner.
//  A per-word start offset lets the first word of a redirected stream begin
//  mid-word.
// PARAMETERS
//  DEPTH  2  number of 64-bit entries; power of 2, >=2 (2 gives full throughput)
// PORTS
//  clk       in   1   clock
//  rst       in   1   reset, synchronous, active-high
//  flush     in   1   synchronous discard of all stored data (stream redirect)
//  a_data    in   64  incoming word
//  a_offset  in   2   first parcel index to emit from a_data (0 = [63:48])
//  a_valid   in   1   incoming word valid
//  a_ready   out  1   FIFO can accept a word this cycle
//  b_data    out  16  outgoing parcel
//  b_valid   out  1   outgoing parcel valid
//  b_ready   in   1   consumer accepts parcel
// BEHAVIOUR
//  Storage and pointers
//  - DEPTH entries of {data[63:0], offset[1:0]} in a circular buffer.
//  - wr_ptr, rd_ptr: $clog2(DEPTH) bits, wrap naturally.
//  - count: $clog2(DEPTH+1) bits.
//  - pidx[1:0]: parcel index of the head entry.
//  Handshakes
//  - Push = a_valid && a_ready. Pop parcel = b_valid && b_ready.
//  - Word retire = pop while pidx==3.
//  - a_ready = (count != DEPTH) && !flush && !rst. Registered state only; no
//    path from b_ready.
//  - b_valid = (count != 0). b_data = head.data[63-16*pidx -: 16].
//  - b_data is don't-care when b_valid=0.
//  Latency and throughput
//  - A word pushed in cycle N gives its first parcel on b in cycle N+1.
//  - No bypass from a to b.
//  - Steady state with b_ready=1 and DEPTH>=2: one parcel per cycle, no bubbles.
//  Parcel sequencing
//  - When a word becomes head (push into empty FIFO, or retire of previous head),
//    pidx loads that word's stored offset.
//  - Each pop: pidx += 1. On pidx==3 the pop retires the word: rd_ptr += 1.
//  - Offset 3 therefore yields exactly one parcel ([15:0]).
//  Simultaneous events
//  - Push and retire in the same cycle: count unchanged, both pointers advance.
//  - Push into an empty FIFO: pidx loads a_offset.
//  - Retire with count>1: pidx loads the next entry's offset.
//  - Push while full is impossible (a_ready=0). a_valid is ignored.
//  Flush
//  - count<=0, rd_ptr<=wr_ptr<=0, pidx<=0 next cycle.
//  - A coincident push or pop is discarded: a_ready=0 during flush.
//  - The b handshake in the flush cycle has no effect on the accepted count.
//  Reset
//  - Same clearing as flush.
//  - Outputs during and after reset: b_valid=0. a_ready=0 while rst is high,
//    1 on the first cycle after.
//  - Reset mid-stream drops all partially emitted words.
//  - Data RAM contents are not reset.
// TESTING
//  1. Single word: push 64'h1111_2222_3333_4444, offset 0, b_ready=1.
//     -> b_data = 1111, 2222, 3333, 4444 in cycles N+1..N+4; then b_valid=0.
//  2. Back-to-back: 4 words pushed whenever a_ready, b_ready=1.
//     -> 16 consecutive valid parcels, no gap.
//     -> a_ready never blocks more than 3 cycles per word.
//  3. Offset: push AAAA_BBBB_CCCC_DDDD offset 2, then 0123_4567_89AB_CDEF offset 0.
//     -> parcels CCCC, DDDD, 0123, 4567, 89AB, CDEF.
//  4. Backpressure: fill DEPTH words with b_ready=0.
//     -> a_ready=0, b_data holds first parcel stable.
//     -> Release b_ready: all 4*DEPTH parcels emitted in order.
//  5. Flush: flush asserted mid-word (pidx=1) together with a_valid.
//     -> next cycle b_valid=0, count=0.
//     -> Flushed word is not emitted. Next push emits from its own offset.
//  6. Reset: assert rst for 1 cycle mid-stream.
//     -> b_valid=0 and a_ready=0 during rst, a_ready=1 after.
//     -> No stale parcels appear.

Source files
------------

// File: rtl/fifo_1d_64to16_if.sv
// Bus bundle for the 64-to-16 downsizer: word input side (a_*), parcel output
// side (b_*) and the stream-redirect flush.
interface fifo_1d_64to16_if;
    logic        flush;
    logic [63:0] a_data;
    logic [1:0]  a_offset;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;

    // FIFO side
    modport slave (
        input  flush, a_data, a_offset, a_valid, b_ready,
        output a_ready, b_data, b_valid
    );

    // Producer/consumer side
    modport master (
        output flush, a_data, a_offset, a_valid, b_ready,
        input  a_ready, b_data, b_valid
    );
endinterface

// File: rtl/fifo_1d_64to16.sv
// Width downsizer FIFO: stores 64-bit words and emits them as 16-bit parcels,
// high parcel first, starting each word at its stored parcel offset.
module fifo_1d_64to16 #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_1d_64to16_if.slave         io_bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   r_data [DEPTH];
    logic [1:0]    r_off  [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_pidx;

    logic          w_aReady;
    logic          w_bValid;
    logic          w_push;
    logic          w_pop;
    logic          w_retire;
    logic [PW-1:0] w_rdNext;
    logic [63:0]   w_head;

    // Readiness comes only from registered state plus flush/rst, never from b_ready.
    assign w_aReady = (r_count != FULL) && !io_bus.flush && !rst;
    assign w_bValid = (r_count != '0) && !rst;

    assign w_push   = io_bus.a_valid && w_aReady;
    assign w_pop    = w_bValid && io_bus.b_ready && !io_bus.flush;
    assign w_retire = w_pop && (r_pidx == 2'd3);
    assign w_rdNext = r_rdPtr + PW'(1);
    assign w_head   = r_data[r_rdPtr];

    assign io_bus.a_ready = w_aReady;
    assign io_bus.b_valid = w_bValid;

    always_comb begin
        io_bus.b_data = w_head[63:48];
        case (r_pidx)
            2'd0: io_bus.b_data = w_head[63:48];
            2'd1: io_bus.b_data = w_head[47:32];
            2'd2: io_bus.b_data = w_head[31:16];
            2'd3: io_bus.b_data = w_head[15:0];
            default: io_bus.b_data = w_head[63:48];
        endcase
    end

    // Storage RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wrPtr] <= io_bus.a_data;
            r_off[r_wrPtr]  <= io_bus.a_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || io_bus.flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_pidx  <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_retire) begin
                r_rdPtr <= w_rdNext;
            end

            if (w_push && !w_retire) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_retire) begin
                r_count <= r_count - CW'(1);
            end

            // A new head takes its offset from RAM, or straight from the input
            // when it is being written in this very cycle.
            if (w_retire) begin
                if (r_count > CW'(1)) begin
                    r_pidx <= r_off[w_rdNext];
                end else if (w_push) begin
                    r_pidx <= io_bus.a_offset;
                end else begin
                    r_pidx <= '0;
                end
            end else if (w_push && (r_count == '0)) begin
                r_pidx <= io_bus.a_offset;
            end else if (w_pop) begin
                r_pidx <= r_pidx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_1d_64to16.sv
// Directed bench for fifo_1d_64to16: a per-cycle vector table plus hand-written
// sequences for back-to-back streaming, backpressure, flush and reset.
module tb_fifo_1d_64to16;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        aValid;
        logic [63:0] aData;
        logic [1:0]  aOffset;
        logic        bReady;
        logic        expAReady;
        logic        expBValid;
        logic [15:0] expBData;
    } vec_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    fifo_1d_64to16_if bus ();

    fifo_1d_64to16 #(.DEPTH(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic f, input logic av,
                                input logic [63:0] d, input logic [1:0] off,
                                input logic br, input logic ear, input logic ebv,
                                input logic [15:0] ebd);
        vec_t v;
        v.rst = r; v.flush = f; v.aValid = av; v.aData = d; v.aOffset = off;
        v.bReady = br; v.expAReady = ear; v.expBValid = ebv; v.expBData = ebd;
        return v;
    endfunction

    function automatic logic [63:0] word16(input logic [15:0] base);
        return {base, base + 16'd1, base + 16'd2, base + 16'd3};
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst          = v.rst;
        bus.flush    = v.flush;
        bus.a_valid  = v.aValid;
        bus.a_data   = v.aData;
        bus.a_offset = v.aOffset;
        bus.b_ready  = v.bReady;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic idle(input logic br);
        applyStimulus(mk(1'b0, 1'b0, 1'b0, 64'h0, 2'd0, br, 1'b0, 1'b0, 16'h0));
    endtask

    vec_t vecs[$];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.a_valid  = 1'b0;
        bus.a_data   = '0;
        bus.a_offset = '0;
        bus.b_ready  = 1'b0;

        // rst, flush, aValid, aData, aOffset, bReady | aReady, bValid, bData
        vecs.push_back(mk(1, 0, 0, 64'h0,                 0, 1, 0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 64'h1111_2222_3333_4444, 0, 1, 1, 0, 16'h0));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'h1111));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'h2222));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'h3333));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'h4444));
        vecs.push_back(mk(0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 2, 1, 1, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 1, 1, 1, 16'hCCCC));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 0, 1, 16'hDDDD));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'h0123));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'h4567));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'h89AB));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'hCDEF));
        vecs.push_back(mk(0, 0, 1, 64'h5555_6666_7777_8888, 3, 1, 1, 0, 16'h0));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 1, 16'h8888));
        vecs.push_back(mk(0, 1, 1, 64'h9999_9999_9999_9999, 0, 1, 0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 0, 64'h0,                 0, 1, 1, 0, 16'h0));

        // Bring the design into a known state before the table starts.
        applyStimulus(mk(1, 0, 0, 64'h0, 0, 0, 0, 0, 16'h0));
        applyStimulus(mk(1, 0, 0, 64'h0, 0, 0, 0, 0, 16'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d a_ready", i), 64'(bus.a_ready), 64'(vecs[i].expAReady));
            checkOutput($sformatf("vec%0d b_valid", i), 64'(bus.b_valid), 64'(vecs[i].expBValid));
            if (vecs[i].expBValid) begin
                checkOutput($sformatf("vec%0d b_data", i), 64'(bus.b_data), 64'(vecs[i].expBData));
            end
        end

        // Back-to-back: four words, producer pushes whenever ready.
        begin
            int k = 0, got = 0, cyc = 0, waitRun = 0, maxWait = 0, firstCyc = -1, lastCyc = -1;
            while (got < 16 && cyc < 80) begin
                applyStimulus(mk(0, 0, (k < 4), word16(16'hB000 + 16'(4 * k)), 0, 1, 0, 0, 16'h0));
                #1;
                if (bus.a_valid && !bus.a_ready) waitRun++;
                else waitRun = 0;
                if (waitRun > maxWait) maxWait = waitRun;
                if (bus.a_valid && bus.a_ready) k++;
                if (bus.b_valid) begin
                    checkOutput($sformatf("b2b parcel%0d", got), 64'(bus.b_data), 64'(16'hB000 + 16'(got)));
                    if (firstCyc < 0) firstCyc = cyc;
                    lastCyc = cyc;
                    got++;
                end
                cyc++;
            end
            checkOutput("b2b parcel count", 64'(got), 64'd16);
            checkOutput("b2b gapless span", 64'(lastCyc - firstCyc), 64'd15);
            checkOutput("b2b ready wait <= 3", 64'(maxWait <= 3), 64'd1);
            idle(1'b1);
            #1;
            checkOutput("b2b drained b_valid", 64'(bus.b_valid), 64'd0);
        end

        // Backpressure: fill both entries, hold, then drain.
        begin
            int got = 0, cyc = 0;
            applyStimulus(mk(0, 0, 1, word16(16'hC000), 0, 0, 0, 0, 16'h0));
            #1;
            checkOutput("bp push0 a_ready", 64'(bus.a_ready), 64'd1);
            applyStimulus(mk(0, 0, 1, word16(16'hC004), 0, 0, 0, 0, 16'h0));
            #1;
            checkOutput("bp push1 a_ready", 64'(bus.a_ready), 64'd1);
            for (int h = 0; h < 3; h++) begin
                applyStimulus(mk(0, 0, 1, word16(16'hE000), 0, 0, 0, 0, 16'h0));
                #1;
                checkOutput($sformatf("bp hold%0d a_ready", h), 64'(bus.a_ready), 64'd0);
                checkOutput($sformatf("bp hold%0d b_data", h), 64'(bus.b_data), 64'hC000);
            end
            while (got < 8 && cyc < 30) begin
                idle(1'b1);
                #1;
                if (bus.b_valid) begin
                    checkOutput($sformatf("bp parcel%0d", got), 64'(bus.b_data), 64'(16'hC000 + 16'(got)));
                    got++;
                end
                cyc++;
            end
            checkOutput("bp parcel count", 64'(got), 64'd8);
            idle(1'b1);
            #1;
            checkOutput("bp drained b_valid", 64'(bus.b_valid), 64'd0);
        end

        // Flush mid-word together with a push; the next word starts at its offset.
        applyStimulus(mk(0, 0, 1, word16(16'hD000), 0, 0, 0, 0, 16'h0));
        applyStimulus(mk(0, 0, 0, 64'h0, 0, 1, 0, 0, 16'h0));
        #1;
        checkOutput("fl first parcel", 64'(bus.b_data), 64'hD000);
        applyStimulus(mk(0, 1, 1, word16(16'hE100), 0, 1, 0, 0, 16'h0));
        #1;
        checkOutput("fl a_ready in flush", 64'(bus.a_ready), 64'd0);
        idle(1'b1);
        #1;
        checkOutput("fl b_valid after", 64'(bus.b_valid), 64'd0);
        checkOutput("fl a_ready after", 64'(bus.a_ready), 64'd1);
        applyStimulus(mk(0, 0, 1, word16(16'hF000), 1, 1, 0, 0, 16'h0));
        for (int p = 1; p < 4; p++) begin
            idle(1'b1);
            #1;
            checkOutput($sformatf("fl new b_valid%0d", p), 64'(bus.b_valid), 64'd1);
            checkOutput($sformatf("fl new parcel%0d", p), 64'(bus.b_data), 64'(16'hF000 + 16'(p)));
        end
        idle(1'b1);
        #1;
        checkOutput("fl new drained", 64'(bus.b_valid), 64'd0);

        // Reset for one cycle mid-word drops the partially emitted word.
        applyStimulus(mk(0, 0, 1, 64'h1234_5678_9ABC_DEF0, 0, 1, 0, 0, 16'h0));
        idle(1'b1);
        #1;
        checkOutput("rs first parcel", 64'(bus.b_data), 64'h1234);
        applyStimulus(mk(1, 0, 1, word16(16'hE200), 0, 1, 0, 0, 16'h0));
        #1;
        checkOutput("rs a_ready in rst", 64'(bus.a_ready), 64'd0);
        checkOutput("rs b_valid in rst", 64'(bus.b_valid), 64'd0);
        idle(1'b1);
        #1;
        checkOutput("rs a_ready after", 64'(bus.a_ready), 64'd1);
        checkOutput("rs b_valid after", 64'(bus.b_valid), 64'd0);
        for (int q = 0; q < 3; q++) begin
            idle(1'b1);
            #1;
            checkOutput($sformatf("rs no stale%0d", q), 64'(bus.b_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
